tdc_sync_multi: RTL

TDC_SYNC_MULTI -- requirements
Module: tdc_sync_multi

---
 rtl/tdc_sync_multi.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/tdc_sync_multi.sv
// ---------------------------------------------------------------------------
// tdc_sync_multi
//
// Multi-channel trigger synchronizer for a TDC front end. Each channel samples
// an asynchronous trigger on both clock edges. It then picks one of the two
// sampled paths with a per-channel phase select and turns each rising event
// into a single one-cycle sync pulse. After each pulse the channel is blind
// for a programmable dead time. A trigger that stays high gives exactly one
// pulse. Each channel also keeps a saturating event counter with a sticky
// overflow flag.
//
// Parameters
//   NCH   number of trigger channels (1..16)
//   DEAD  dead-time cycles after each pulse (1..15)
//   CNTW  width of each per-channel event counter (2..16)
//
// Ports
//   clk5         clock; negedge used only by the negedge sampling flop
//   rst_n        asynchronous active-low reset for every flop
//   TDC_trigger  [NCH]       asynchronous trigger inputs
//   s            [NCH]       phase select: 0 = negedge path, 1 = posedge path
//   en           global enable for starting new events
//   clr_cnt      synchronous clear of all counters and overflow flags
//   sync         [NCH]       one-cycle registered pulse per accepted event
//   sync_any     OR of all sync bits, same cycle as sync
//   cnt          [NCH*CNTW]  channel c count at bits [c*CNTW +: CNTW]
//   ovf          [NCH]       sticky counter saturation flags
// ---------------------------------------------------------------------------
module tdc_sync_multi #(
    parameter int NCH  = 4,
    parameter int DEAD = 2,
    parameter int CNTW = 8
) (
    input  logic                 clk5,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       TDC_trigger,
    input  logic [NCH-1:0]       s,
    input  logic                 en,
    input  logic                 clr_cnt,
    output logic [NCH-1:0]       sync,
    output logic                 sync_any,
    output logic [NCH*CNTW-1:0]  cnt,
    output logic [NCH-1:0]       ovf
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PULSE,
        ST_DEAD,
        ST_WAIT_LOW
    } state_t;

    // The dead counter is loaded with DEAD-1 when leaving PULSE. It then
    // counts down to zero, so the channel spends exactly DEAD cycles in DEAD.
    localparam logic [3:0] DEAD_LOAD = 4'(DEAD - 1);

    for (genvar c = 0; c < NCH; c++) begin : g_ch

        logic            r_n0;
        logic            r_p0;
        logic            r_n1;
        logic            r_p1;
        logic            r_s_lat;
        state_t          r_state;
        logic [3:0]      r_dead;
        logic            r_sync;
        logic [CNTW-1:0] r_cnt;
        logic            r_ovf;
        logic            w_v;
        logic            w_start;

        // First sampling stage of the negedge path.
        always_ff @(negedge clk5 or negedge rst_n) begin
            if (!rst_n) begin
                r_n0 <= 1'b0;
            end else begin
                r_n0 <= TDC_trigger[c];
            end
        end

        // Posedge first stage, plus the second stage of both paths. After
        // this, both paths are on the posedge clock domain.
        always_ff @(posedge clk5 or negedge rst_n) begin
            if (!rst_n) begin
                r_p0 <= 1'b0;
                r_n1 <= 1'b0;
                r_p1 <= 1'b0;
            end else begin
                r_p0 <= TDC_trigger[c];
                r_n1 <= r_n0;
                r_p1 <= r_p0;
            end
        end

        // The phase select is latched only while idle, so a change of s in
        // the middle of an event cannot switch paths under that event.
        assign w_v     = r_s_lat ? r_p1 : r_n1;
        assign w_start = (r_state == ST_IDLE) && en && w_v;

        // Event FSM. sync is registered here and is high exactly while in
        // PULSE. Once an event has started it runs to completion, whatever
        // en does.
        always_ff @(posedge clk5 or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= ST_IDLE;
                r_dead  <= 4'd0;
                r_sync  <= 1'b0;
                r_s_lat <= 1'b0;
            end else begin
                r_sync <= 1'b0;
                case (r_state)
                    ST_IDLE: begin
                        r_s_lat <= s[c];
                        if (w_start) begin
                            r_state <= ST_PULSE;
                            r_sync  <= 1'b1;
                        end
                    end
                    ST_PULSE: begin
                        r_state <= ST_DEAD;
                        r_dead  <= DEAD_LOAD;
                    end
                    ST_DEAD: begin
                        // When the dead time runs out, a level that is still
                        // high must first go low before it can be re-armed.
                        if (r_dead == 4'd0) begin
                            r_state <= w_v ? ST_WAIT_LOW : ST_IDLE;
                        end else begin
                            r_dead <= r_dead - 4'd1;
                        end
                    end
                    ST_WAIT_LOW: begin
                        if (!w_v) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end

        // Saturating event counter. A clear wins over an increment in the
        // same cycle, so that event is dropped from the count.
        always_ff @(posedge clk5 or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= '0;
                r_ovf <= 1'b0;
            end else if (clr_cnt) begin
                r_cnt <= '0;
                r_ovf <= 1'b0;
            end else if (w_start) begin
                if (&r_cnt) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CNTW'(1);
                end
            end
        end

        assign sync[c]               = r_sync;
        assign cnt[c*CNTW +: CNTW]   = r_cnt;
        assign ovf[c]                = r_ovf;
    end

    assign sync_any = |sync;

endmodule
